// File: rtl/alu_regs_seq.sv
// Micro-sequencer that walks a register-file/ALU datapath through read, execute
// and write-back phases for one MIPS R-type instruction at a time.
module alu_regs_seq #(
    parameter int X_LEN            = 32,
    parameter bit WB_ZERO_SUPPRESS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [X_LEN-1:0] inst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [3:0]       FR,
    output logic [4:0]       R_Addr_A,
    output logic [4:0]       R_Addr_B,
    output logic [4:0]       W_Addr,
    output logic [3:0]       ALU_OP,
    output logic             en_RR,
    output logic             en_F,
    output logic             en_WB,
    output logic             Reg_Write,
    output logic             done,
    output logic [3:0]       flags_out,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RR   = 3'd1,
        S_EX   = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] ra_q, ra_d;
    logic [4:0] rb_q, rb_d;
    logic [4:0] wa_q, wa_d;
    logic [3:0] op_q, op_d;
    logic [3:0] flags_q, flags_d;
    logic       ill_q, ill_d;

    logic       dec_legal;
    logic [3:0] dec_op;
    logic       accept;

    // Combinational decode of the offered word; only consumed on a handshake.
    always_comb begin
        dec_legal = 1'b1;
        dec_op    = 4'b0000;
        case (inst[5:0])
            6'h24:   dec_op = 4'b0000;
            6'h25:   dec_op = 4'b0001;
            6'h26:   dec_op = 4'b0010;
            6'h27:   dec_op = 4'b0011;
            6'h20:   dec_op = 4'b0100;
            6'h22:   dec_op = 4'b0101;
            6'h2B:   dec_op = 4'b0110;
            6'h04:   dec_op = 4'b0111;
            default: dec_legal = 1'b0;
        endcase
        if (inst[31:26] != 6'd0 || inst[10:6] != 5'd0) begin
            dec_legal = 1'b0;
        end
        if (!dec_legal) begin
            dec_op = 4'b0000;
        end
    end

    assign accept = inst_valid && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        wa_d    = wa_q;
        op_d    = op_q;
        flags_d = flags_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ra_d    = inst[25:21];
                    rb_d    = inst[20:16];
                    wa_d    = inst[15:11];
                    op_d    = dec_op;
                    ill_d   = !dec_legal;
                    // Illegal words skip every datapath phase.
                    state_d = dec_legal ? S_RR : S_DONE;
                end
            end
            S_RR:   state_d = S_EX;
            S_EX:   state_d = S_WB;
            S_WB: begin
                flags_d = FR;
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ra_q    <= 5'd0;
            rb_q    <= 5'd0;
            wa_q    <= 5'd0;
            op_q    <= 4'd0;
            flags_q <= 4'd0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            wa_q    <= wa_d;
            op_q    <= op_d;
            flags_q <= flags_d;
            ill_q   <= ill_d;
        end
    end

    // Strobes decode straight from state so an async reset kills them at once.
    assign inst_ready = (state_q == S_IDLE);
    assign en_RR      = (state_q == S_RR);
    assign en_F       = (state_q == S_EX);
    assign en_WB      = (state_q == S_WB);
    assign Reg_Write  = en_WB && !(WB_ZERO_SUPPRESS && (wa_q == 5'd0));
    assign done       = (state_q == S_DONE);
    assign illegal    = done && ill_q;

    assign R_Addr_A   = ra_q;
    assign R_Addr_B   = rb_q;
    assign W_Addr     = wa_q;
    assign ALU_OP     = op_q;
    assign flags_out  = flags_q;

endmodule

// File: tb/tb_alu_regs_seq.sv
// Randomised self-checking bench for alu_regs_seq against a cycle-offset model.
module tb_alu_regs_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'd0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [3:0]  FR = 4'd0;
    logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
    logic [3:0]  ALU_OP;
    logic        en_RR, en_F, en_WB, Reg_Write, done, illegal;
    logic [3:0]  flags_out;

    int checks = 0;
    int fails  = 0;

    logic [6:0]  obs_trace [1:5];
    logic [3:0]  obs_flags [1:5];
    logic [4:0]  obs_ra, obs_rb, obs_wa;
    logic [3:0]  obs_op;
    logic [3:0]  exp_flags = 4'd0;

    alu_regs_seq #(.X_LEN(32), .WB_ZERO_SUPPRESS(1'b1)) dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .FR(FR), .R_Addr_A(R_Addr_A),
        .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .ALU_OP(ALU_OP),
        .en_RR(en_RR), .en_F(en_F), .en_WB(en_WB), .Reg_Write(Reg_Write),
        .done(done), .flags_out(flags_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic is_legal(input logic [31:0] w);
        logic f;
        f = (w[5:0] == 6'h24) || (w[5:0] == 6'h25) || (w[5:0] == 6'h26) ||
            (w[5:0] == 6'h27) || (w[5:0] == 6'h20) || (w[5:0] == 6'h22) ||
            (w[5:0] == 6'h2B) || (w[5:0] == 6'h04);
        return f && (w[31:26] == 6'd0) && (w[10:6] == 5'd0);
    endfunction

    function automatic logic [3:0] exp_op(input logic [31:0] w);
        case (w[5:0])
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h26: return 4'b0010;
            6'h27: return 4'b0011;
            6'h20: return 4'b0100;
            6'h22: return 4'b0101;
            6'h2B: return 4'b0110;
            default: return 4'b0111;
        endcase
    endfunction

    // {inst_ready, en_RR, en_F, en_WB, Reg_Write, done, illegal} k cycles after accept
    function automatic logic [6:0] exp_trace(input logic [31:0] w, input int k);
        if (is_legal(w)) begin
            case (k)
                1: return 7'b0100000;
                2: return 7'b0010000;
                3: return {4'b0001, (w[15:11] != 5'd0), 2'b00};
                4: return 7'b0000010;
                default: return 7'b1000000;
            endcase
        end
        return (k == 1) ? 7'b0000011 : 7'b1000000;
    endfunction

    function automatic int trace_len(input logic [31:0] w);
        return is_legal(w) ? 5 : 2;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one word, then records the outputs for each cycle after acceptance.
    task automatic issue(input logic [31:0] w, input logic [3:0] fr);
        int n;
        n = 0;
        while (!inst_ready && n < 20) begin
            step();
            n++;
        end
        if (!inst_ready) begin
            checks++;
            fails++;
            $display("FAIL issue_ready_timeout got ready=%b want 1", inst_ready);
        end
        inst = w;
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        inst = $urandom;
        obs_ra = R_Addr_A;
        obs_rb = R_Addr_B;
        obs_wa = W_Addr;
        obs_op = ALU_OP;
        for (int k = 1; k <= trace_len(w); k++) begin
            FR = (k == 3) ? fr : 4'($urandom);
            obs_trace[k] = {inst_ready, en_RR, en_F, en_WB, Reg_Write, done, illegal};
            obs_flags[k] = flags_out;
            if (k < trace_len(w)) step();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        inst_valid = 1'b1;
        inst = 32'h01095020;
        #3;
        checks++;
        if ({inst_ready, en_RR, en_F, en_WB, Reg_Write, done, illegal} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 1000000",
                     {inst_ready, en_RR, en_F, en_WB, Reg_Write, done, illegal});
        end
        checks++;
        if ({R_Addr_A, R_Addr_B, W_Addr, ALU_OP, flags_out} !== 23'd0) begin
            fails++;
            $display("FAIL reset_regs got %h want 0",
                     {R_Addr_A, R_Addr_B, W_Addr, ALU_OP, flags_out});
        end
        inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        logic [3:0] fr;
        logic [31:0] w;
        w = 32'h01095020;
        fr = 4'b0110;
        issue(w, fr);
        checks++;
        if ({obs_ra, obs_rb, obs_wa, obs_op} !== {5'd8, 5'd9, 5'd10, 4'b0100}) begin
            fails++;
            $display("FAIL add_fields got %0d/%0d/%0d/%b want 8/9/10/0100",
                     obs_ra, obs_rb, obs_wa, obs_op);
        end
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (obs_trace[k] !== exp_trace(w, k)) begin
                fails++;
                $display("FAIL add_trace k=%0d got %b want %b", k, obs_trace[k], exp_trace(w, k));
            end
        end
        exp_flags = fr;
        checks++;
        if (obs_flags[4] !== exp_flags) begin
            fails++;
            $display("FAIL add_flags got %b want %b", obs_flags[4], exp_flags);
        end
    endtask

    task automatic test_rd_zero();
        logic [31:0] w;
        w = 32'h01090022;
        issue(w, 4'b0001);
        exp_flags = 4'b0001;
        checks++;
        if (obs_op !== 4'b0101) begin
            fails++;
            $display("FAIL rdzero_op got %b want 0101", obs_op);
        end
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (obs_trace[k] !== exp_trace(w, k)) begin
                fails++;
                $display("FAIL rdzero_trace k=%0d got %b want %b", k, obs_trace[k], exp_trace(w, k));
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] w;
        w = 32'h8C000000;
        issue(w, 4'b1111);
        for (int k = 1; k <= 2; k++) begin
            checks++;
            if (obs_trace[k] !== exp_trace(w, k)) begin
                fails++;
                $display("FAIL illegal_trace k=%0d got %b want %b", k, obs_trace[k], exp_trace(w, k));
            end
            checks++;
            if (obs_flags[k] !== exp_flags) begin
                fails++;
                $display("FAIL illegal_flags k=%0d got %b want %b", k, obs_flags[k], exp_flags);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] fbb;
        fbb = 4'b1010;
        FR = fbb;
        inst = 32'h01095024;
        inst_valid = 1'b1;
        step();
        inst = 32'h01095027;
        checks++;
        if (ALU_OP !== 4'b0000) begin
            fails++;
            $display("FAIL b2b_op1 got %b want 0000", ALU_OP);
        end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (inst_ready !== 1'b0) begin
                fails++;
                $display("FAIL b2b_ready_low k=%0d got %b want 0", k, inst_ready);
            end
            step();
        end
        checks++;
        if (inst_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready_t5 got %b want 1", inst_ready);
        end
        step();
        inst_valid = 1'b0;
        checks++;
        if ({en_RR, ALU_OP} !== 5'b10011) begin
            fails++;
            $display("FAIL b2b_second got en_RR=%b op=%b want 1/0011", en_RR, ALU_OP);
        end
        for (int k = 0; k < 4; k++) step();
        exp_flags = fbb;
        checks++;
        if ({inst_ready, flags_out} !== {1'b1, fbb}) begin
            fails++;
            $display("FAIL b2b_end got ready=%b flags=%b want 1/%b", inst_ready, flags_out, fbb);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] w;
        w = 32'h01095020;
        inst = w;
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        step();
        checks++;
        if (en_F !== 1'b1) begin
            fails++;
            $display("FAIL midop_in_ex got en_F=%b want 1", en_F);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({inst_ready, en_RR, en_F, en_WB, Reg_Write, done, illegal} !== 7'b1000000) begin
            fails++;
            $display("FAIL midop_abort got %b want 1000000",
                     {inst_ready, en_RR, en_F, en_WB, Reg_Write, done, illegal});
        end
        exp_flags = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({inst_ready, Reg_Write, done} !== 3'b100) begin
                fails++;
                $display("FAIL midop_idle k=%0d got %b want 100", k, {inst_ready, Reg_Write, done});
            end
        end
        issue(w, 4'b0101);
        exp_flags = 4'b0101;
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (obs_trace[k] !== exp_trace(w, k)) begin
                fails++;
                $display("FAIL midop_fresh k=%0d got %b want %b", k, obs_trace[k], exp_trace(w, k));
            end
        end
    endtask

    task automatic test_flags();
        logic [3:0] prev;
        prev = exp_flags;
        issue(32'h01084822, 4'b1000);
        checks++;
        if ({obs_flags[3], obs_flags[4], obs_flags[5]} !== {prev, 4'b1000, 4'b1000}) begin
            fails++;
            $display("FAIL flags_capture got %b/%b/%b want %b/1000/1000",
                     obs_flags[3], obs_flags[4], obs_flags[5], prev);
        end
        issue(32'h01095020, 4'b0011);
        checks++;
        if ({obs_flags[1], obs_flags[2], obs_flags[3], obs_flags[4]} !== {12'b100010001000, 4'b0011}) begin
            fails++;
            $display("FAIL flags_hold got %b/%b/%b/%b want 1000/1000/1000/0011",
                     obs_flags[1], obs_flags[2], obs_flags[3], obs_flags[4]);
        end
        exp_flags = 4'b0011;
    endtask

    task automatic test_random();
        logic [5:0]  funct_tbl [0:7];
        logic [31:0] w;
        logic [3:0]  fr;
        int kind;
        funct_tbl = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2B, 6'h04};
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            w = {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0,
                 funct_tbl[$urandom_range(0, 7)]};
            if (kind == 2) w[10:6] = 5'($urandom_range(1, 31));
            if (kind == 3) w = $urandom;
            fr = 4'($urandom);
            issue(w, fr);
            for (int k = 1; k <= trace_len(w); k++) begin
                checks++;
                if (obs_trace[k] !== exp_trace(w, k)) begin
                    fails++;
                    $display("FAIL rand_trace i=%0d w=%h k=%0d got %b want %b",
                             i, w, k, obs_trace[k], exp_trace(w, k));
                end
            end
            if (is_legal(w)) begin
                checks++;
                if ({obs_ra, obs_rb, obs_wa, obs_op} !== {w[25:21], w[20:16], w[15:11], exp_op(w)}) begin
                    fails++;
                    $display("FAIL rand_fields i=%0d w=%h got %h want %h", i, w,
                             {obs_ra, obs_rb, obs_wa, obs_op},
                             {w[25:21], w[20:16], w[15:11], exp_op(w)});
                end
                checks++;
                if (obs_flags[3] !== exp_flags || obs_flags[5] !== fr) begin
                    fails++;
                    $display("FAIL rand_flags i=%0d got %b/%b want %b/%b",
                             i, obs_flags[3], obs_flags[5], exp_flags, fr);
                end
                exp_flags = fr;
            end else begin
                checks++;
                if (obs_flags[2] !== exp_flags) begin
                    fails++;
                    $display("FAIL rand_illegal_flags i=%0d got %b want %b", i, obs_flags[2], exp_flags);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_rd_zero();
        test_illegal();
        test_back_to_back();
        test_reset_midop();
        test_flags();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
